// File: rtl/spi_slave_core.sv
// SPI responder core: oversampled SCK/NSS/MOSI, CPOL/CPHA edge decode, MISO moves SYNC_STAGES+1 clocks after SCK.
// Backpressure: single-entry tx buffer (tx_ready_o low when full or disabled); rx words are pulsed with no backpressure.
module spi_slave_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsb_i,
  input  logic                  spi_sck_i,
  input  logic                  spi_nss_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  udr_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync, nss_sync, mosi_sync;
  logic                   sck_prev, nss_prev;
  logic                   sck_cur, nss_cur, mosi_cur;
  logic                   sck_rise, sck_fall, lead_edge, trail_edge;
  logic                   sample_edge, shift_edge, nss_fall, nss_rise;

  logic [CW-1:0]          cnt_q;
  logic                   load_pend_q;
  logic                   full_q;
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_next, tx_shift_q, buf_q;
  logic                   do_load, set_pend, do_sample, do_shift, clr_frame;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync  <= '0;
      nss_sync  <= '1;
      mosi_sync <= '0;
      sck_prev  <= 1'b0;
      nss_prev  <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi_nss_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sck_prev  <= sck_cur;
      nss_prev  <= nss_cur;
    end
  end

  assign sck_cur     = sck_sync[SYNC_STAGES-1];
  assign nss_cur     = nss_sync[SYNC_STAGES-1];
  assign mosi_cur    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise    = sck_cur & ~sck_prev;
  assign sck_fall    = ~sck_cur & sck_prev;
  assign nss_fall    = ~nss_cur & nss_prev;
  assign nss_rise    = nss_cur & ~nss_prev;
  assign lead_edge   = cpol_i ? sck_fall : sck_rise;
  assign trail_edge  = cpol_i ? sck_rise : sck_fall;
  assign sample_edge = cpha_i ? trail_edge : lead_edge;
  assign shift_edge  = cpha_i ? lead_edge : trail_edge;

  assign rx_next = lsb_i ? {mosi_cur, rx_shift_q[DATA_WIDTH-1:1]}
                         : {rx_shift_q[DATA_WIDTH-2:0], mosi_cur};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    do_load   = 1'b0;
    set_pend  = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;
    clr_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && nss_fall) begin
          state_d = ACTIVE;
          // With CPHA=1 the first bit is driven on the first leading edge, so defer the load.
          if (cpha_i) set_pend = 1'b1;
          else        do_load  = 1'b1;
        end
      end
      ACTIVE: begin
        if (!en_i || nss_rise) begin
          state_d   = IDLE;
          clr_frame = 1'b1;
        end else if (sample_edge) begin
          do_sample = 1'b1;
        end else if (shift_edge) begin
          if (load_pend_q) do_load  = 1'b1;
          else             do_shift = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q       <= '0;
      load_pend_q <= 1'b0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      full_q      <= 1'b0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      udr_o       <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      udr_o      <= 1'b0;

      if (clr_frame) begin
        cnt_q       <= '0;
        load_pend_q <= 1'b0;
      end
      if (set_pend) load_pend_q <= 1'b1;

      if (do_sample) begin
        rx_shift_q <= rx_next;
        if (cnt_q == LAST_BIT) begin
          cnt_q       <= '0;
          load_pend_q <= 1'b1;
          rx_data_o   <= rx_next;
          rx_valid_o  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      if (do_shift) begin
        tx_shift_q <= lsb_i ? {1'b0, tx_shift_q[DATA_WIDTH-1:1]}
                            : {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
      end

      if (do_load) begin
        load_pend_q <= 1'b0;
        if (full_q) begin
          tx_shift_q <= buf_q;
        end else begin
          tx_shift_q <= '0;
          udr_o      <= 1'b1;
        end
      end

      // A write landing with an underrun load is kept for the following word.
      if (!en_i)                      full_q <= 1'b0;
      else if (do_load && full_q)     full_q <= 1'b0;
      else if (tx_valid_i && tx_ready_o) begin
        full_q <= 1'b1;
        buf_q  <= tx_data_i;
      end
    end
  end

  assign tx_ready_o    = en_i & ~full_q;
  assign busy_o        = (state_q == ACTIVE);
  assign spi_miso_oe_o = busy_o;
  assign spi_miso_o    = busy_o & (lsb_i ? tx_shift_q[0] : tx_shift_q[DATA_WIDTH-1]);

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a bit-banged SPI master, a directed vector table and randomized frames.
module tb_spi_slave_core;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int HP = 6;

  logic         clk_i = 1'b0;
  logic         rst_n_i, en_i, cpol_i, cpha_i, lsb_i;
  logic         spi_sck_i, spi_nss_i, spi_mosi_i;
  logic         spi_miso_o, spi_miso_oe_o;
  logic [W-1:0] tx_data_i, rx_data_o;
  logic         tx_valid_i, tx_ready_o, rx_valid_o, udr_o, busy_o;

  spi_slave_core #(.DATA_WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .en_i         (en_i),
    .cpol_i       (cpol_i),
    .cpha_i       (cpha_i),
    .lsb_i        (lsb_i),
    .spi_sck_i    (spi_sck_i),
    .spi_nss_i    (spi_nss_i),
    .spi_mosi_i   (spi_mosi_i),
    .spi_miso_o   (spi_miso_o),
    .spi_miso_oe_o(spi_miso_oe_o),
    .tx_data_i    (tx_data_i),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .udr_o        (udr_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] rx_log [0:1023];
  int rx_n  = 0;
  int udr_n = 0;

  always @(negedge clk_i) begin
    if (rst_n_i === 1'b1) begin
      if (rx_valid_o === 1'b1) begin
        rx_log[rx_n] = rx_data_o;
        rx_n++;
      end
      if (udr_o === 1'b1) udr_n++;
    end
  end

  typedef struct {
    logic         cpol, cpha, lsb, has_tx;
    logic [W-1:0] tx, mosi, exp_miso, exp_rx;
    int           exp_udr;
  } vec_t;
  vec_t vecs [6];

  logic [W-1:0] mst_w [4];
  logic [W-1:0] tx_w [4];
  logic [W-1:0] got_miso [4];
  logic         has_tx [4];
  logic         skip_write0;
  int           oe_low;

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic bit_of(input logic [W-1:0] w, input int i, input logic lsb);
    return lsb ? w[i] : w[W-1-i];
  endfunction

  task automatic tx_write(input logic [W-1:0] d, output int used);
    used = 0;
    tx_data_i  = d;
    tx_valid_i = 1'b1;
    while (!tx_ready_o && used < 20) begin
      tick(1);
      used++;
    end
    chk("tx_ready_wait", tx_ready_o, 1);
    tick(1);
    used++;
    tx_valid_i = 1'b0;
  endtask

  // Master side of one NSS-low frame; returns early (SCK idle, NSS low) before bit stop_bit of word 0.
  task automatic run_frame(input logic cpol, input logic cpha, input logic lsb,
                           input int nw, input int stop_bit);
    int used, rdy_at;
    cpol_i = cpol; cpha_i = cpha; lsb_i = lsb;
    spi_sck_i = cpol; spi_nss_i = 1'b1; spi_mosi_i = 1'b0;
    oe_low = 0;
    for (int k = 0; k < 4; k++) got_miso[k] = '0;
    tick(8);
    if (has_tx[0] && !skip_write0) tx_write(tx_w[0], used);
    tick(2);
    spi_nss_i = 1'b0;
    if (!cpha) spi_mosi_i = bit_of(mst_w[0], 0, lsb);
    rdy_at = -1;
    for (int i = 1; i <= HP; i++) begin
      tick(1);
      if (tx_ready_o && rdy_at < 0) rdy_at = i;
    end
    if (!cpha && has_tx[0] && !skip_write0) chk("tx_ready_after_load", rdy_at, SS + 1);
    for (int w = 0; w < nw; w++) begin
      for (int b = 0; b < W; b++) begin
        if (w == 0 && b == stop_bit) return;
        if (cpha) spi_mosi_i = bit_of(mst_w[w], b, lsb);
        else begin
          got_miso[w][lsb ? b : W-1-b] = spi_miso_o;
          if (!spi_miso_oe_o) oe_low++;
        end
        spi_sck_i = ~cpol;
        used = 0;
        if (b == 3 && w + 1 < nw && has_tx[w+1]) tx_write(tx_w[w+1], used);
        if (used < HP) tick(HP - used);
        if (cpha) begin
          got_miso[w][lsb ? b : W-1-b] = spi_miso_o;
          if (!spi_miso_oe_o) oe_low++;
        end else if (b < W - 1) spi_mosi_i = bit_of(mst_w[w], b + 1, lsb);
        else if (w + 1 < nw)    spi_mosi_i = bit_of(mst_w[w+1], 0, lsb);
        spi_sck_i = cpol;
        tick(HP);
      end
    end
    spi_nss_i = 1'b1;
    tick(HP);
  endtask

  // Expected results straight from the frame description: rx = master words,
  // MISO word = the word offered for it (else zero), one underrun per missing word,
  // plus the extra trailing-edge load that CPHA=0 performs after the last word.
  task automatic check_frame(input logic cpha, input int nw, input int rx_base, input int udr_base);
    int exp_udr;
    exp_udr = cpha ? 0 : 1;
    chk("rx_count", rx_n - rx_base, nw);
    for (int k = 0; k < nw; k++) begin
      chk($sformatf("rx_word%0d", k), rx_log[rx_base + k], mst_w[k]);
      chk($sformatf("miso_word%0d", k), got_miso[k], has_tx[k] ? tx_w[k] : {W{1'b0}});
      if (!has_tx[k]) exp_udr++;
    end
    chk("udr_count", udr_n - udr_base, exp_udr);
    chk("oe_during_frame", oe_low, 0);
    chk("busy_after_frame", busy_o, 0);
    chk("miso_after_frame", spi_miso_o, 0);
  endtask

  initial begin
    int rb, ub, nw;
    logic rp, rh, rl;

    rst_n_i = 1'b0; en_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0;
    spi_sck_i = 1'b0; spi_nss_i = 1'b1; spi_mosi_i = 1'b0;
    tx_data_i = '0; tx_valid_i = 1'b0; skip_write0 = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h55, 8'h00, 8'h55, 1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h96, 8'h0F, 8'h96, 8'h0F, 1};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 8'hE1, 8'hC3, 8'hE1, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h80, 8'h00, 8'h80, 2};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 8'hFE, 8'h01, 8'hFE, 0};

    tick(3);
    chk("rst_miso", spi_miso_o, 0);
    chk("rst_oe", spi_miso_oe_o, 0);
    chk("rst_rx_data", rx_data_o, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_udr", udr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_tx_ready", tx_ready_o, 1);
    en_i = 1'b0;
    #1 chk("rst_tx_ready_disabled", tx_ready_o, 0);
    en_i = 1'b1;
    tick(1);
    rst_n_i = 1'b1;
    tick(4);

    for (int v = 0; v < 6; v++) begin
      mst_w[0] = vecs[v].mosi; tx_w[0] = vecs[v].tx; has_tx[0] = vecs[v].has_tx;
      rb = rx_n; ub = udr_n;
      run_frame(vecs[v].cpol, vecs[v].cpha, vecs[v].lsb, 1, -1);
      chk($sformatf("vec%0d_rx_count", v), rx_n - rb, 1);
      chk($sformatf("vec%0d_rx_data", v), rx_data_o, vecs[v].exp_rx);
      chk($sformatf("vec%0d_miso", v), got_miso[0], vecs[v].exp_miso);
      chk($sformatf("vec%0d_udr", v), udr_n - ub, vecs[v].exp_udr);
    end

    // Two words in one frame, mode 3 LSB first, second tx word written mid-word.
    mst_w[0] = 8'h81; mst_w[1] = 8'h7E; tx_w[0] = 8'h12; tx_w[1] = 8'h34;
    has_tx[0] = 1'b1; has_tx[1] = 1'b1;
    rb = rx_n; ub = udr_n;
    run_frame(1'b1, 1'b1, 1'b1, 2, -1);
    check_frame(1'b1, 2, rb, ub);

    // NSS abort after 5 bits; the buffered next word must survive into the next frame.
    mst_w[0] = 8'hAA; tx_w[0] = 8'h5A; tx_w[1] = 8'h0F; has_tx[0] = 1'b1; has_tx[1] = 1'b1;
    rb = rx_n;
    run_frame(1'b0, 1'b0, 1'b0, 2, 5);
    spi_nss_i = 1'b1;
    tick(HP);
    chk("abort_no_rx", rx_n - rb, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_buffer_kept", tx_ready_o, 0);
    mst_w[0] = 8'hF0; tx_w[0] = 8'h0F; has_tx[0] = 1'b1; skip_write0 = 1'b1;
    rb = rx_n; ub = udr_n;
    run_frame(1'b0, 1'b0, 1'b0, 1, -1);
    skip_write0 = 1'b0;
    check_frame(1'b0, 1, rb, ub);

    // en_i dropped mid-word with a word waiting in the buffer.
    mst_w[0] = 8'h3A; tx_w[0] = 8'h99; tx_w[1] = 8'h66; has_tx[0] = 1'b1; has_tx[1] = 1'b1;
    rb = rx_n;
    run_frame(1'b0, 1'b0, 1'b0, 2, 5);
    en_i = 1'b0;
    tick(1);
    chk("endrop_busy", busy_o, 0);
    chk("endrop_oe", spi_miso_oe_o, 0);
    chk("endrop_miso", spi_miso_o, 0);
    chk("endrop_tx_ready", tx_ready_o, 0);
    spi_nss_i = 1'b1;
    tick(HP);
    en_i = 1'b1;
    tick(2);
    chk("endrop_no_rx", rx_n - rb, 0);
    chk("endrop_buffer_emptied", tx_ready_o, 1);
    mst_w[0] = 8'hBD; tx_w[0] = 8'h24; has_tx[0] = 1'b1;
    rb = rx_n; ub = udr_n;
    run_frame(1'b0, 1'b0, 1'b0, 1, -1);
    check_frame(1'b0, 1, rb, ub);

    // Asynchronous reset between clock edges in the middle of a mode 2 frame.
    mst_w[0] = 8'h11; tx_w[0] = 8'h77; has_tx[0] = 1'b1;
    run_frame(1'b1, 1'b0, 1'b0, 1, 4);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_miso", spi_miso_o, 0);
    chk("arst_oe", spi_miso_oe_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_rx_data", rx_data_o, 0);
    chk("arst_rx_valid", rx_valid_o, 0);
    chk("arst_udr", udr_o, 0);
    chk("arst_tx_ready", tx_ready_o, 1);
    tick(1);
    spi_nss_i = 1'b1;
    spi_sck_i = 1'b1;
    tick(2);
    rst_n_i = 1'b1;
    tick(4);
    mst_w[0] = 8'hC3; tx_w[0] = 8'h3C; has_tx[0] = 1'b1;
    rb = rx_n; ub = udr_n;
    run_frame(1'b1, 1'b0, 1'b0, 1, -1);
    check_frame(1'b0, 1, rb, ub);

    for (int r = 0; r < 20; r++) begin
      nw = $urandom_range(1, 3);
      rp = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        mst_w[k]  = W'($urandom);
        tx_w[k]   = W'($urandom);
        has_tx[k] = 1'($urandom_range(0, 1));
      end
      rb = rx_n; ub = udr_n;
      run_frame(rp, rh, rl, nw, -1);
      check_frame(rh, nw, rb, ub);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
SPI responder (slave) datapath, the far end of the master clock/shift logic. It oversamples an external SCK/NSS/MOSI with the system clock, decodes CPOL/CPHA edges, and shifts one DATA_WIDTH word per frame segment. Received words go out as a one-cycle valid pulse, and transmit words come in through a single-entry valid/ready buffer. It sits between the SPI pads and the register/FIFO layer.

Parameters:
DATA_WIDTH, 8, bits per word (≥2)
SYNC_STAGES, 2, synchronizer flops on spi_sck_i/spi_nss_i/spi_mosi_i (≥2)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
en_i  in  1  block enable
cpol_i  in  1  SCK idle level
cpha_i  in  1  0: sample leading edge, 1: sample trailing edge
lsb_i  in  1  1: LSB first, 0: MSB first
spi_sck_i  in  1  external SCK (async)
spi_nss_i  in  1  external select, active low (async)
spi_mosi_i  in  1  external MOSI (async)
spi_miso_o  out  1  MISO data
spi_miso_oe_o  out  1  MISO output enable
tx_data_i  in  DATA_WIDTH  word to transmit
tx_valid_i  in  1  tx word offered
tx_ready_o  out  1  tx buffer empty and en_i=1
rx_data_o  out  DATA_WIDTH  last received word
rx_valid_o  out  1  one-cycle pulse, rx_data_o updated
udr_o  out  1  one-cycle pulse, word loaded while tx buffer empty
busy_o  out  1  frame active

Behaviour:
- Clock and reset: one clock clk_i. Reset rst_n_i is asynchronous and active-low. All flops reset.
- Reset values: spi_miso_o=0, spi_miso_oe_o=0, rx_data_o=0, rx_valid_o=0, udr_o=0, busy_o=0, buffer empty, NSS synchronizer =1, SCK/MOSI synchronizers =0.
- Synchronizers and edge detect: SCK, NSS and MOSI each pass through SYNC_STAGES flops. One extra SCK history flop gives rise = cur&~prev and fall = ~cur&prev.
- Edge roles: leading = cpol_i ? fall : rise; trailing = the other. Sample edge = cpha_i ? trailing : leading. Shift edge = the other one.
- SCK edges are ignored unless state=ACTIVE.
- Timing requirement: each SCK half-period lasts at least 4 clk_i cycles. MISO changes SYNC_STAGES+1 clk_i cycles after the external SCK edge.
- FSM IDLE: busy_o=0, oe=0.
  - Synced NSS falling with en_i=1 goes to ACTIVE.
  - On entry, bit counter=0. If cpha_i=0, load the tx word immediately. If cpha_i=1, set load_pend.
- FSM ACTIVE: busy_o=1, oe=1.
  - Sample edge: shift the synced MOSI into rx_shift (MSB- or LSB-side per lsb_i) and increment the counter.
  - When the counter reaches DATA_WIDTH: rx_data_o gets the full word and rx_valid_o pulses in the next cycle. The counter wraps to 0 and load_pend is set.
  - Shift edge: if load_pend, load the tx word and clear load_pend. Otherwise advance tx_shift by one bit.
  - spi_miso_o = tx_shift[DATA_WIDTH-1] when lsb_i=0, tx_shift[0] when lsb_i=1.
  - Synced NSS rising, or en_i=0, returns to IDLE.
- Load rule:
  - Buffer full: tx_shift gets the buffer and the buffer is emptied.
  - Buffer empty: tx_shift gets all-zero and udr_o pulses one cycle.
  - A tx write in the same cycle as a load into an empty buffer does not rescue that load. It fills the buffer for the next word.
- TX buffer: tx_ready_o = en_i & ~full, combinational. A write happens only when tx_valid_i & tx_ready_o.
- Abort (NSS rises with counter ≠ 0): the partial rx word is dropped with no rx_valid_o. Counter and load_pend are cleared. The tx buffer keeps its content. The next frame starts at bit 0.
- en_i low (any time): return to IDLE, empty the buffer, clear the counter, oe=0, spi_miso_o=0. rx_data_o holds its value.
- IDLE and oe=0 force spi_miso_o=0.
- cpol_i, cpha_i and lsb_i are static while busy_o=1. Behaviour is undefined if they change mid-frame.

Test Plan:
1. Mode 0, MSB first, 0xA5 written before NSS falls, master sends 0x3C → MISO bits sampled 1,0,1,0,0,1,0,1; rx_data_o=0x3C with a single-cycle rx_valid_o; tx_ready_o returns to 1 one cycle after NSS-fall load.
2. Mode 3, LSB first, tx 0x12 then 0x34 (second written during word 1), master sends 0x81,0x7E in one NSS-low frame → MISO 0x12 then 0x34 LSB first; two rx_valid_o pulses with 0x81, 0x7E; no udr_o.
3. Mode 1, no tx write, master sends 0x55 → one udr_o pulse at the first leading edge, MISO constant 0, rx_data_o=0x55.
4. Mode 0, NSS raised after 5 bits, then a new frame with master data 0xF0 and tx 0x0F → no rx_valid_o for the aborted word; the second frame gives rx_data_o=0xF0, MISO=0x0F.
5. en_i dropped mid-word → spi_miso_oe_o=0 and busy_o=0 next cycle, tx_ready_o=0, no rx_valid_o; re-enable plus a full frame → correct transfer.
6. rst_n_i asserted mid-frame (asynchronous, between clk_i edges) → all outputs at reset values immediately; after release a mode 2 frame 0xC3/0x3C completes correctly.
